// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Processes one input bit per clock. It also produces a leading-zero
// blanking mask and an overflow flag for the display path.
// A valid/ready handshake is used on the input side.
// A single-cycle o_valid pulse announces each new result.

module bin_to_bcd_seq #(
    parameter int IN_W       = 16,
    parameter int BCD_DIGITS = 5,
    parameter int OUT_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_W-1:0]         i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [4*OUT_DIGITS-1:0] o_bcd,
    output logic [OUT_DIGITS-1:0]   o_blank,
    output logic                    o_ovf,
    output logic                    o_valid
);

    localparam int ACC_W = 4 * BCD_DIGITS;
    localparam int OUT_W = 4 * OUT_DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(IN_W - 1);
    localparam logic [OUT_DIGITS-1:0] BLANK_RST = {OUT_DIGITS{1'b1}} << 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                  r_state;
    logic [IN_W-1:0]         r_bin;
    logic [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ready;
    logic                    r_valid;
    logic [OUT_W-1:0]        r_bcd;
    logic [OUT_DIGITS-1:0]   r_blank;
    logic                    r_ovf;

    // Adjusted accumulator. The top digit keeps only its low three bits,
    // because its bit 3 is shifted out and is always zero anyway.
    logic [ACC_W-2:0]        w_adj;
    logic [ACC_W-1:0]        w_acc_next;
    logic [IN_W-1:0]         w_bin_next;
    logic                    w_last;
    logic                    w_ovf;
    logic [OUT_W-1:0]        w_bcd_out;
    logic [OUT_DIGITS-1:0]   w_blank;
    logic [OUT_DIGITS:1]     w_zero_from;

    // Per-digit add-3 correction. The adjusted value is at most 12, so no
    // carry has to ripple into the next digit.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            logic [3:0] w_dig;
            assign w_dig = r_acc[4*gi +: 4];
            if (gi < BCD_DIGITS - 1) begin : g_full
                assign w_adj[4*gi +: 4] = (w_dig >= 4'd5) ? w_dig + 4'd3 : w_dig;
            end else begin : g_top
                assign w_adj[4*gi +: 3] = 3'((w_dig >= 4'd5) ? w_dig + 4'd3 : w_dig);
            end
        end
    endgenerate

    // One double-dabble step: shift {acc, bin} left and feed the binary MSB
    // into accumulator bit 0.
    assign w_acc_next = {w_adj, r_bin[IN_W-1]};
    assign w_bin_next = r_bin << 1;
    assign w_last     = (r_cnt == LAST_CNT);

    // Overflow occurs when any digit above the presented ones is nonzero.
    // If every internal digit is presented, overflow is impossible.
    generate
        if (OUT_DIGITS < BCD_DIGITS) begin : g_ovf
            assign w_ovf = |w_acc_next[ACC_W-1:OUT_W];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    // On overflow, saturate the display to all nines.
    assign w_bcd_out = w_ovf ? {OUT_DIGITS{4'h9}} : w_acc_next[OUT_W-1:0];

    // Leading-zero mask. Digit d is blank when it and every digit above it
    // is zero. The ones digit is never blanked, so a value of 0 still
    // shows one digit.
    assign w_zero_from[OUT_DIGITS] = (w_bcd_out[4*(OUT_DIGITS-1) +: 4] == 4'd0);
    assign w_blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < OUT_DIGITS; gi++) begin : g_blank
            if (gi < OUT_DIGITS - 1) begin : g_mid
                assign w_zero_from[gi] = (w_bcd_out[4*gi +: 4] == 4'd0) && w_zero_from[gi+1];
            end else begin : g_msd
                assign w_zero_from[gi] = w_zero_from[OUT_DIGITS];
            end
            assign w_blank[gi] = w_zero_from[gi];
        end
    endgenerate

    // Handshake FSM and datapath. All outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_bcd   <= '0;
            r_blank <= BLANK_RST;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_bin   <= i_data;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_acc_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd   <= w_bcd_out;
                        r_blank <= w_blank;
                        r_ovf   <= w_ovf;
                        r_valid <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_bcd   = r_bcd;
    assign o_blank = r_blank;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq at default parameters.
// Expected results come from a decimal reference model that uses plain
// division and modulo.

module tb_bin_to_bcd_seq;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst    = 1'b0;
    logic [15:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] o_bcd;
    logic [3:0]  o_blank;
    logic        o_ovf;
    logic        o_valid;

    int n_pass  = 0;
    int n_total = 0;

    bin_to_bcd_seq #(.IN_W(16), .BCD_DIGITS(5), .OUT_DIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_bcd   (o_bcd),
        .o_blank (o_blank),
        .o_ovf   (o_ovf),
        .o_valid (o_valid)
    );

    always #5 if (clk_en) clk = ~clk;

    // Decimal reference. Values above 9999 saturate to 9999 and raise ovf.
    function automatic void ref_model(input int unsigned v, output logic [15:0] bcd,
                                      output logic [3:0] blank, output logic ovf);
        if (v > 9999) begin
            bcd = 16'h9999; blank = 4'b0000; ovf = 1'b1;
        end else begin
            ovf = 1'b0;
            for (int d = 0; d < 4; d++) begin
                bcd[4*d +: 4] = 4'((v / (10 ** d)) % 10);
                blank[d]      = (d > 0) && (v < (10 ** d));
            end
        end
    endfunction

    // Run one conversion and return what was observed. The caller does the
    // comparisons. Inputs are scrambled while the converter is busy.
    task automatic do_conv(input logic [15:0] v, output logic [15:0] bcd, output logic [3:0] blank,
                           output logic ovf, output int lat, output bit busy_ok,
                           output logic valid_after, output logic [15:0] bcd_after);
        int w = 0;
        while (!o_ready && w < 40) begin @(negedge clk); w++; end
        i_data = v; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0; i_data = 16'($urandom);
        busy_ok = 1'b1; lat = 0;
        while (!o_valid && lat < 40) begin
            if (o_ready) busy_ok = 1'b0;
            i_valid = 1'($urandom_range(0, 1));
            i_data  = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        i_valid = 1'b0;
        if (!o_valid) lat = -1;
        bcd = o_bcd; blank = o_blank; ovf = o_ovf;
        @(negedge clk);
        valid_after = o_valid; bcd_after = o_bcd;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_total++; if (o_bcd !== 16'h0000) $display("FAIL reset_bcd: got %h expected 0000", o_bcd); else n_pass++;
        n_total++; if (o_blank !== 4'b1110) $display("FAIL reset_blank: got %b expected 1110", o_blank); else n_pass++;
        n_total++; if (o_ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", o_ovf); else n_pass++;
        n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else n_pass++;
        n_total++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_ready); else n_pass++;
        rst = 1'b0;
        #2;
        n_total++;
        if (o_bcd !== 16'h0000 || o_blank !== 4'b1110 || o_ready !== 1'b1 || o_valid !== 1'b0)
            $display("FAIL reset_release: got bcd=%h blank=%b ready=%b valid=%b expected 0000/1110/1/0",
                     o_bcd, o_blank, o_ready, o_valid);
        else n_pass++;
        $display("reset: bcd=%h blank=%b ready=%b", o_bcd, o_blank, o_ready);
        clk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [15:0] bcd, bcd_after; logic [3:0] blank; logic ovf, va; int lat; bit busy_ok;
        do_conv(16'd1234, bcd, blank, ovf, lat, busy_ok, va, bcd_after);
        $display("conv 1234: bcd=%h blank=%b ovf=%b latency=%0d", bcd, blank, ovf, lat);
        n_total++; if (lat != 16) $display("FAIL basic_latency: got %0d expected 16", lat); else n_pass++;
        n_total++; if (!busy_ok) $display("FAIL basic_busy: got ready high while busy expected low"); else n_pass++;
        n_total++; if (bcd !== 16'h1234) $display("FAIL basic_bcd: got %h expected 1234", bcd); else n_pass++;
        n_total++; if (blank !== 4'b0000) $display("FAIL basic_blank: got %b expected 0000", blank); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", ovf); else n_pass++;
        n_total++; if (va !== 1'b0) $display("FAIL basic_pulse: got valid=%b one cycle later expected 0", va); else n_pass++;
        n_total++; if (bcd_after !== 16'h1234) $display("FAIL basic_hold: got %h expected 1234", bcd_after); else n_pass++;
    endtask

    // Table of boundary values and overflow values with literal expectations.
    task automatic test_edges;
        int unsigned vals[8]   = '{0, 7, 80, 905, 9999, 10000, 65535, 42};
        logic [15:0] ebcd[8]   = '{16'h0000, 16'h0007, 16'h0080, 16'h0905, 16'h9999, 16'h9999, 16'h9999, 16'h0042};
        logic [3:0]  eblank[8] = '{4'b1110, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
        logic        eovf[8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] bcd, bcd_after; logic [3:0] blank; logic ovf, va; int lat; bit busy_ok;
        for (int i = 0; i < 8; i++) begin
            do_conv(16'(vals[i]), bcd, blank, ovf, lat, busy_ok, va, bcd_after);
            $display("conv %0d: bcd=%h blank=%b ovf=%b latency=%0d", vals[i], bcd, blank, ovf, lat);
            n_total++;
            if (bcd !== ebcd[i] || blank !== eblank[i] || ovf !== eovf[i] || lat != 16)
                $display("FAIL edge_%0d: got bcd=%h blank=%b ovf=%b lat=%0d expected %h/%b/%b/16",
                         vals[i], bcd, blank, ovf, lat, ebcd[i], eblank[i], eovf[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [15:0] bcd, bcd_after, ebcd, v; logic [3:0] blank, eblank; logic ovf, eovf, va;
        int lat; bit busy_ok;
        for (int i = 0; i < 12; i++) begin
            v = (i % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            ref_model(v, ebcd, eblank, eovf);
            do_conv(v, bcd, blank, ovf, lat, busy_ok, va, bcd_after);
            $display("rand %0d: bcd=%h blank=%b ovf=%b", v, bcd, blank, ovf);
            n_total++;
            if (bcd !== ebcd || blank !== eblank || ovf !== eovf || lat != 16 || !busy_ok)
                $display("FAIL random_%0d: got bcd=%h blank=%b ovf=%b lat=%0d expected %h/%b/%b/16",
                         v, bcd, blank, ovf, lat, ebcd, eblank, eovf);
            else n_pass++;
        end
    endtask

    // i_valid held high with fresh data every cycle. Accepts must be spaced
    // 17 cycles apart, and each result must match the data accepted.
    task automatic test_back_to_back;
        logic [15:0] q[$];
        logic [15:0] v, got_v, ebcd; logic [3:0] eblank; logic eovf;
        int last = -1, acc = 0, res = 0;
        for (int c = 0; c < 145; c++) begin
            if (o_valid) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL b2b_extra_valid: got o_valid with no pending accept at cycle %0d expected none", c);
                end else begin
                    got_v = q.pop_front();
                    ref_model(got_v, ebcd, eblank, eovf);
                    $display("b2b %0d: bcd=%h blank=%b ovf=%b", got_v, o_bcd, o_blank, o_ovf);
                    if (o_bcd !== ebcd || o_blank !== eblank || o_ovf !== eovf)
                        $display("FAIL b2b_result_%0d: got %h/%b/%b expected %h/%b/%b",
                                 got_v, o_bcd, o_blank, o_ovf, ebcd, eblank, eovf);
                    else n_pass++;
                end
                res++;
            end
            i_valid = (c < 105);
            v = (c % 3 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            i_data = v;
            if (i_valid && o_ready) begin
                if (last >= 0) begin
                    n_total++;
                    if (c - last != 17) $display("FAIL b2b_interval: got %0d expected 17", c - last);
                    else n_pass++;
                end
                q.push_back(v);
                last = c;
                acc++;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        n_total++; if (acc != 7) $display("FAIL b2b_accepts: got %0d expected 7", acc); else n_pass++;
        n_total++; if (res != acc) $display("FAIL b2b_results: got %0d expected %0d", res, acc); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [15:0] bcd, bcd_after; logic [3:0] blank; logic ovf, va; int lat; bit busy_ok;
        int stray = 0;
        while (!o_ready) @(negedge clk);
        i_data = 16'd4321; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (o_bcd !== 16'h0000 || o_blank !== 4'b1110 || o_ovf !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0)
            $display("FAIL midreset_state: got bcd=%h blank=%b ovf=%b ready=%b valid=%b expected 0000/1110/0/1/0",
                     o_bcd, o_blank, o_ovf, o_ready, o_valid);
        else n_pass++;
        #1 rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_valid) stray++;
        end
        n_total++; if (stray != 0) $display("FAIL midreset_no_valid: got %0d pulses expected 0", stray); else n_pass++;
        do_conv(16'd56, bcd, blank, ovf, lat, busy_ok, va, bcd_after);
        $display("conv 56 after reset: bcd=%h blank=%b ovf=%b latency=%0d", bcd, blank, ovf, lat);
        n_total++;
        if (bcd !== 16'h0056 || blank !== 4'b1100 || ovf !== 1'b0 || lat != 16)
            $display("FAIL midreset_recover: got %h/%b/%b lat=%0d expected 0056/1100/0/16", bcd, blank, ovf, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_edges;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
